actuator_sequencer: RTL and testbench
=====================================

# actuator_sequencer

Downstream of the insert/release control FSM: consumes its one-hot command levels (EN_INSERT, EN_RELEASE, EN_RESET, EN_ALARM) and turns them into timed, interlocked motor-drive strokes bounded by two limit switches. Enforces dead-time between direction changes, a stroke timeout, and a latched fault that only a reset command clears. Reports stroke completion and errors back to system logic.

## Interface
- DEAD_CYCLES, 4: cycles with both motor outputs low before any drive starts (≥1).
- TIMEOUT_CYCLES, 1000: maximum drive cycles before a stroke is declared failed (≥2).
- CNT_W, 16: counter width; must hold max(DEAD_CYCLES, TIMEOUT_CYCLES).
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- EN_INSERT  in  1  command: drive forward to LIMIT_IN.
- EN_RELEASE  in  1  command: drive reverse to LIMIT_OUT.
- EN_RESET  in  1  command: home (reverse to LIMIT_OUT) and clear fault.
- EN_ALARM  in  1  command: immediate stop, enter fault.
- LIMIT_IN  in  1  asynchronous limit switch, inserted position.
- LIMIT_OUT  in  1  asynchronous limit switch, released/home position.
- MOTOR_FWD  out  1  forward drive.
- MOTOR_REV  out  1  reverse drive.
- BUSY  out  1  high in any state except IDLE and FAULT.
- DONE  out  1  one-cycle pulse on successful stroke end.
- TIMEOUT_ERR  out  1  latched: fault caused by timeout.
- SENSOR_ERR  out  1  latched: fault caused by both limits active.
- FAULT_OUT  out  1  high while in FAULT.

## Operation
- LIMIT_IN/LIMIT_OUT pass through 2-flop synchronizers; all decisions use synchronized values (limI, limO).
- States: IDLE, DEAD, DRIVE, DONE_WAIT, FAULT.
- Command priority evaluated every cycle: ALARM > RESET > INSERT > RELEASE.
- IDLE: highest-priority command latched as target (INSERT→FWD/limI; RELEASE, RESET→REV/limO); go DEAD, counter cleared. ALARM → FAULT.
- DEAD: motors low for exactly DEAD_CYCLES cycles, then: target limit already active → DONE_WAIT with no drive; else → DRIVE.
- DRIVE: exactly one motor output high per target. Target limit active → motors low, DONE pulse, DONE_WAIT. Counter reaches TIMEOUT_CYCLES → FAULT, TIMEOUT_ERR=1.
- Latched target holds for the whole stroke; command deassertion or lower-priority command mid-stroke ignored.
- ALARM in any state → FAULT next cycle, motors low that cycle.
- limI && limO in DEAD or DRIVE → FAULT, SENSOR_ERR=1.
- DONE_WAIT: hold until all four commands low, then IDLE (no retrigger on held level). RESET stroke completion clears TIMEOUT_ERR/SENSOR_ERR.
- FAULT: motors low, FAULT_OUT=1. Exit only on EN_RESET with EN_ALARM low → DEAD with REV/limO target; error flags stay set until that homing stroke completes.
- MOTOR_FWD && MOTOR_REV never both high, any cycle.

## Timing
- Reset: state IDLE; MOTOR_FWD, MOTOR_REV, BUSY, DONE, TIMEOUT_ERR, SENSOR_ERR, FAULT_OUT all 0; counters and synchronizers 0.
- All outputs registered.
- Command sampled in IDLE at edge N → BUSY=1 after N; motor high after edge N+DEAD_CYCLES+1.
- Limit pin change → visible to FSM 2 cycles later; motor drops and DONE pulses on the following edge (3-cycle pin-to-stop).
- Timeout: motor high for exactly TIMEOUT_CYCLES cycles, then low with FAULT_OUT=1 in the same cycle.
- Reset asserted mid-stroke: outputs low asynchronously, no DONE.

## Structure
- Shared package act_seq_pkg: state enum (IDLE, DEAD, DRIVE, DONE_WAIT, FAULT), direction constants (DIR_FWD, DIR_REV).
- Sub-module sync_2ff (one bit, rst_n async clear), instantiated twice for limit switches.

## Test plan
- DEAD_CYCLES=4: EN_INSERT pulse, LIMIT_IN raised 20 cycles into drive → MOTOR_FWD high 5 cycles after sample, low 3 cycles after LIMIT_IN, single DONE pulse, IDLE after EN_INSERT drops.
- TIMEOUT_CYCLES=100: EN_RELEASE, limits never asserted → MOTOR_REV high exactly 100 cycles, then FAULT_OUT=1, TIMEOUT_ERR=1; further EN_INSERT ignored.
- From FAULT: EN_RESET with LIMIT_OUT already high → no motor pulse, DONE once, TIMEOUT_ERR cleared, IDLE.
- EN_ALARM asserted 10 cycles into FWD drive → motor low next cycle, FAULT_OUT=1; EN_RESET while EN_ALARM high stays in FAULT.
- LIMIT_IN and LIMIT_OUT both high during drive → FAULT, SENSOR_ERR=1, motors low.
- EN_INSERT and EN_RELEASE same cycle → forward stroke only; rst_n low mid-stroke → all outputs 0 immediately.

Source files
------------

// File: rtl/act_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : act_seq_pkg
// Description : Shared state encoding and drive-direction constants for the
//               actuator sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package act_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEAD      = 3'd1,
    DRIVE     = 3'd2,
    DONE_WAIT = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Forward strokes end on the inserted switch, reverse strokes on home.
  function automatic logic target_hit(input logic dir, input logic lim_i, input logic lim_o);
    return (dir == DIR_FWD) ? lim_i : lim_o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit two-flop synchronizer with asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/actuator_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : actuator_sequencer
// Description : Turns one-hot insert/release/reset/alarm command levels into
//               dead-timed, limit-bounded, timeout-guarded motor strokes.
// Revision    : 1.0 - initial release
// ============================================================================
module actuator_sequencer
  import act_seq_pkg::*;
#(
  parameter int DEAD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic EN_INSERT,
  input  logic EN_RELEASE,
  input  logic EN_RESET,
  input  logic EN_ALARM,
  input  logic LIMIT_IN,
  input  logic LIMIT_OUT,
  output logic MOTOR_FWD,
  output logic MOTOR_REV,
  output logic BUSY,
  output logic DONE,
  output logic TIMEOUT_ERR,
  output logic SENSOR_ERR,
  output logic FAULT_OUT
);

  localparam logic [CNT_W-1:0] C_DEAD_END = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] C_TMO_END  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  logic w_lim_i;
  logic w_lim_o;

  sync_2ff u_sync_lim_in (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (LIMIT_IN),
    .q     (w_lim_i)
  );

  sync_2ff u_sync_lim_out (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (LIMIT_OUT),
    .q     (w_lim_o)
  );

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_is_reset;
  logic             r_fwd;
  logic             r_rev;
  logic             r_busy;
  logic             r_done;
  logic             r_tmo;
  logic             r_sens;
  logic             r_fault;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_next_dir;
  logic             w_next_is_reset;
  logic             w_next_done;
  logic             w_next_tmo;
  logic             w_next_sens;
  logic             w_hit;
  logic             w_both;
  logic             w_any_cmd;

  assign w_hit     = target_hit(r_dir, w_lim_i, w_lim_o);
  assign w_both    = w_lim_i && w_lim_o;
  assign w_any_cmd = EN_INSERT || EN_RELEASE || EN_RESET || EN_ALARM;

  always_comb begin
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;
    w_next_dir      = r_dir;
    w_next_is_reset = r_is_reset;
    w_next_done     = 1'b0;
    w_next_tmo      = r_tmo;
    w_next_sens     = r_sens;

    case (r_state)
      IDLE: begin
        w_next_cnt = '0;
        if (EN_ALARM) begin
          w_next_state = FAULT;
        end else if (EN_RESET) begin
          w_next_state    = DEAD;
          w_next_dir      = DIR_REV;
          w_next_is_reset = 1'b1;
        end else if (EN_INSERT) begin
          w_next_state    = DEAD;
          w_next_dir      = DIR_FWD;
          w_next_is_reset = 1'b0;
        end else if (EN_RELEASE) begin
          w_next_state    = DEAD;
          w_next_dir      = DIR_REV;
          w_next_is_reset = 1'b0;
        end
      end

      DEAD: begin
        if (EN_ALARM) begin
          w_next_state = FAULT;
        end else if (w_both) begin
          w_next_state = FAULT;
          w_next_sens  = 1'b1;
        end else if (r_cnt == C_DEAD_END) begin
          if (w_hit) begin
            // Already at the target: complete the stroke without driving.
            w_next_state = DONE_WAIT;
            w_next_done  = 1'b1;
            if (r_is_reset) begin
              w_next_tmo  = 1'b0;
              w_next_sens = 1'b0;
            end
          end else begin
            w_next_state = DRIVE;
            w_next_cnt   = C_ONE;
          end
        end else begin
          w_next_cnt = r_cnt + C_ONE;
        end
      end

      DRIVE: begin
        // r_cnt equals the number of cycles the motor has been driven so far.
        if (EN_ALARM) begin
          w_next_state = FAULT;
        end else if (w_both) begin
          w_next_state = FAULT;
          w_next_sens  = 1'b1;
        end else if (w_hit) begin
          w_next_state = DONE_WAIT;
          w_next_done  = 1'b1;
          if (r_is_reset) begin
            w_next_tmo  = 1'b0;
            w_next_sens = 1'b0;
          end
        end else if (r_cnt == C_TMO_END) begin
          w_next_state = FAULT;
          w_next_tmo   = 1'b1;
        end else begin
          w_next_cnt = r_cnt + C_ONE;
        end
      end

      DONE_WAIT: begin
        if (EN_ALARM) begin
          w_next_state = FAULT;
        end else if (!w_any_cmd) begin
          w_next_state = IDLE;
        end
      end

      FAULT: begin
        if (EN_RESET && !EN_ALARM) begin
          w_next_state    = DEAD;
          w_next_dir      = DIR_REV;
          w_next_is_reset = 1'b1;
          w_next_cnt      = '0;
        end
      end

      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dir      <= DIR_FWD;
      r_is_reset <= 1'b0;
      r_fwd      <= 1'b0;
      r_rev      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tmo      <= 1'b0;
      r_sens     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_dir      <= w_next_dir;
      r_is_reset <= w_next_is_reset;
      r_fwd      <= (w_next_state == DRIVE) && (w_next_dir == DIR_FWD);
      r_rev      <= (w_next_state == DRIVE) && (w_next_dir == DIR_REV);
      r_busy     <= (w_next_state == DEAD) || (w_next_state == DRIVE) ||
                    (w_next_state == DONE_WAIT);
      r_done     <= w_next_done;
      r_tmo      <= w_next_tmo;
      r_sens     <= w_next_sens;
      r_fault    <= (w_next_state == FAULT);
    end
  end

  assign MOTOR_FWD   = r_fwd;
  assign MOTOR_REV   = r_rev;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign TIMEOUT_ERR = r_tmo;
  assign SENSOR_ERR  = r_sens;
  assign FAULT_OUT   = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_actuator_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_actuator_sequencer
// Description : Directed, table-driven self-checking bench for the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_actuator_sequencer;

  // Command bits {insert, release, reset, alarm}
  localparam logic [3:0] c_none = 4'b0000;
  localparam logic [3:0] c_ins  = 4'b1000;
  localparam logic [3:0] c_rel  = 4'b0100;
  localparam logic [3:0] c_rst  = 4'b0010;
  localparam logic [3:0] c_alm  = 4'b0001;

  // Expected outputs {fwd, rev, busy, done, tmo_err, sens_err, fault}
  localparam logic [6:0] c_o_idle  = 7'b0000000;
  localparam logic [6:0] c_o_busy  = 7'b0010000;
  localparam logic [6:0] c_o_fwd   = 7'b1010000;
  localparam logic [6:0] c_o_rev   = 7'b0110000;
  localparam logic [6:0] c_o_done  = 7'b0011000;
  localparam logic [6:0] c_o_ftmo  = 7'b0000101;
  localparam logic [6:0] c_o_btmo  = 7'b0010100;
  localparam logic [6:0] c_o_fault = 7'b0000001;
  localparam logic [6:0] c_o_fsen  = 7'b0000011;
  localparam logic [6:0] c_o_bsen  = 7'b0010010;

  typedef struct {
    string      name;
    logic [3:0] cmd;
    logic [1:0] lim;   // {LIMIT_IN, LIMIT_OUT}
    int         cycles;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_insert = 1'b0, en_release = 1'b0, en_reset = 1'b0, en_alarm = 1'b0;
  logic limit_in = 1'b0, limit_out = 1'b0;
  logic motor_fwd, motor_rev, busy, done, timeout_err, sensor_err, fault_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_both   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  actuator_sequencer #(
    .DEAD_CYCLES    (4),
    .TIMEOUT_CYCLES (100),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .EN_INSERT   (en_insert),
    .EN_RELEASE  (en_release),
    .EN_RESET    (en_reset),
    .EN_ALARM    (en_alarm),
    .LIMIT_IN    (limit_in),
    .LIMIT_OUT   (limit_out),
    .MOTOR_FWD   (motor_fwd),
    .MOTOR_REV   (motor_rev),
    .BUSY        (busy),
    .DONE        (done),
    .TIMEOUT_ERR (timeout_err),
    .SENSOR_ERR  (sensor_err),
    .FAULT_OUT   (fault_out)
  );

  always @(negedge clk) begin
    if (motor_fwd && motor_rev) n_both++;
  end

  function automatic logic [6:0] outs();
    return {motor_fwd, motor_rev, busy, done, timeout_err, sensor_err, fault_out};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic [3:0] cmd, input logic [1:0] lim,
                     input int cycles, input logic [6:0] exp);
    vec_t v;
    v.name = name; v.cmd = cmd; v.lim = lim; v.cycles = cycles; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    // Insert stroke, LIMIT_IN raised 20 cycles into drive, command held
    add("ins_sample",   c_ins,  2'b00,  1, c_o_busy);
    add("ins_dead",     c_ins,  2'b00,  4, c_o_busy);
    add("ins_motor_on", c_ins,  2'b00,  1, c_o_fwd);
    add("ins_drive",    c_ins,  2'b00, 19, c_o_fwd);
    add("ins_lim_sync", c_ins,  2'b10,  2, c_o_fwd);
    add("ins_done",     c_ins,  2'b10,  1, c_o_done);
    add("ins_hold",     c_ins,  2'b10,  3, c_o_busy);
    add("ins_idle",     c_none, 2'b10,  1, c_o_idle);
    add("idle_quiet",   c_none, 2'b00,  3, c_o_idle);
    // Release stroke with no limits: timeout after exactly 100 drive cycles
    add("rel_sample",   c_rel,  2'b00,  1, c_o_busy);
    add("rel_dead",     c_none, 2'b00,  4, c_o_busy);
    add("rel_motor_on", c_none, 2'b00,  1, c_o_rev);
    add("rel_drive",    c_none, 2'b00, 99, c_o_rev);
    add("rel_timeout",  c_none, 2'b00,  1, c_o_ftmo);
    add("fault_ign_ins",c_ins,  2'b00, 10, c_o_ftmo);
    // Reset from fault, already home: no drive, DONE, errors cleared
    add("home_lim",     c_none, 2'b01,  3, c_o_ftmo);
    add("rst_sample",   c_rst,  2'b01,  1, c_o_btmo);
    add("rst_dead",     c_rst,  2'b01,  4, c_o_btmo);
    add("rst_done",     c_rst,  2'b01,  1, c_o_done);
    add("rst_hold",     c_rst,  2'b01,  2, c_o_busy);
    add("rst_idle",     c_none, 2'b01,  1, c_o_idle);
    // Alarm 10 cycles into forward drive; reset with alarm high is ignored
    add("alm_sample",   c_ins,  2'b00,  1, c_o_busy);
    add("alm_dead",     c_ins,  2'b00,  4, c_o_busy);
    add("alm_motor_on", c_ins,  2'b00,  1, c_o_fwd);
    add("alm_drive",    c_ins,  2'b00,  9, c_o_fwd);
    add("alm_stop",     c_ins | c_alm, 2'b00, 1, c_o_fault);
    add("alm_rst_blk",  c_rst | c_alm, 2'b00, 3, c_o_fault);
    add("alm_rst_go",   c_rst,  2'b01,  1, c_o_busy);
    add("alm_rst_dead", c_rst,  2'b01,  4, c_o_busy);
    add("alm_rst_done", c_rst,  2'b01,  1, c_o_done);
    add("alm_idle",     c_none, 2'b01,  1, c_o_idle);
    // Both limits during drive
    add("sen_sample",   c_ins,  2'b00,  1, c_o_busy);
    add("sen_dead",     c_ins,  2'b00,  4, c_o_busy);
    add("sen_motor_on", c_ins,  2'b00,  1, c_o_fwd);
    add("sen_drive",    c_ins,  2'b00,  5, c_o_fwd);
    add("sen_lim_sync", c_ins,  2'b11,  2, c_o_fwd);
    add("sen_fault",    c_ins,  2'b11,  1, c_o_fsen);
    add("sen_hold",     c_none, 2'b01,  3, c_o_fsen);
    add("sen_rst_go",   c_rst,  2'b01,  1, c_o_bsen);
    add("sen_rst_dead", c_rst,  2'b01,  4, c_o_bsen);
    add("sen_rst_done", c_rst,  2'b01,  1, c_o_done);
    add("sen_idle",     c_none, 2'b01,  1, c_o_idle);
    // Insert and release together: forward only
    add("both_sample",  c_ins | c_rel, 2'b00, 1, c_o_busy);
    add("both_dead",    c_ins | c_rel, 2'b00, 4, c_o_busy);
    add("both_fwd_on",  c_ins | c_rel, 2'b00, 1, c_o_fwd);
    add("both_fwd",     c_ins | c_rel, 2'b00, 3, c_o_fwd);

    // Outputs during and after power-on reset
    repeat (2) tick();
    check("reset_state", outs(), c_o_idle);
    rst_n = 1'b1;
    tick();
    check("post_reset", outs(), c_o_idle);

    foreach (vecs[i]) begin
      {en_insert, en_release, en_reset, en_alarm} = vecs[i].cmd;
      {limit_in, limit_out} = vecs[i].lim;
      for (int k = 0; k < vecs[i].cycles; k++) begin
        tick();
        check(vecs[i].name, outs(), vecs[i].exp);
      end
    end

    // Asynchronous reset mid-stroke: outputs drop before the next edge
    rst_n = 1'b0;
    #2;
    check("async_rst", outs(), c_o_idle);
    tick();
    check("async_rst_hold", outs(), c_o_idle);
    {en_insert, en_release, en_reset, en_alarm} = c_none;
    rst_n = 1'b1;
    repeat (3) tick();
    check("after_rst_idle", outs(), c_o_idle);

    n_checks++;
    if (n_both != 0) begin
      n_fail++;
      $display("FAIL motor_interlock: got %0d overlap cycles expected 0", n_both);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
